custom_axi_ip_sched: RTL and testbench

Round-robin scheduler that shares one `custom_axi_ip` compute engine between `NUM_REQ` requesters. It accepts one request at a time, issues it to the engine and waits for completion through the engine's `status_e` output. It then returns the engine result, or an error, on a single tagged response channel. It sits between the register-side request ports and the engine's `ipreg_data`/`enable_in`/`ipreg_data_out`/`status_out` pins.

---
 rtl/custom_axi_ip_pkg.sv | 21 ++
 rtl/custom_axi_ip_rr_arb.sv | 34 +++
 rtl/custom_axi_ip_sched.sv | 139 +++++++++++++
 tb/tb_custom_axi_ip_sched.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_axi_ip_pkg.sv
// custom_axi_ip_pkg: shared types for the custom_axi_ip engine and its request scheduler.
//   status_e      - engine status reported on status_out
//   sched_state_e - scheduler FSM states
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COLLECT,
        S_RESP
    } sched_state_e;

endpackage

// File: rtl/custom_axi_ip_rr_arb.sv
// custom_axi_ip_rr_arb: combinational round-robin arbiter.
//   req_i        - request vector
//   last_grant_i - index granted last; priority starts just above it and wraps
//   gnt_o        - one-hot grant (all zero when no request)
//   idx_o        - index of the granted requester
module custom_axi_ip_rr_arb
    import custom_axi_ip_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_grant_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o
);

    // Walk from lowest to highest priority so the highest-priority
    // requester is the last one written and therefore wins.
    always_comb begin
        logic [IW-1:0] j;
        gnt_o = '0;
        idx_o = '0;
        j     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = IW'((int'(last_grant_i) + i) % NUM_REQ);
            if (req_i[j]) begin
                idx_o = j;
                gnt_o = NUM_REQ'(1) << j;
            end
        end
    end

endmodule

// File: rtl/custom_axi_ip_sched.sv
// custom_axi_ip_sched: round-robin scheduler sharing one custom_axi_ip engine between NUM_REQ requesters.
//   clk_i, rst_ni             - clock, synchronous active-low reset
//   req_valid_i/req_data_i    - per-requester valid and packed operands
//   req_ready_o               - one-hot grant, only in S_IDLE with the engine IDLE
//   rsp_valid_o/id/data/err   - tagged response, held until rsp_ready_i
//   eng_data_o/eng_enable_o   - operand and one-cycle start pulse to the engine
//   eng_status_i/eng_result_i - engine status and result
//   busy_o                    - high whenever the FSM is not in S_IDLE
module custom_axi_ip_sched
    import custom_axi_ip_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int TIMEOUT    = 16,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          rsp_valid_o,
    output logic [IW-1:0]                 rsp_id_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_err_o,
    input  logic                          rsp_ready_i,
    output logic [31:0]                   eng_data_o,
    output logic                          eng_enable_o,
    input  status_e                       eng_status_i,
    input  logic [31:0]                   eng_result_i,
    output logic                          busy_o
);

    localparam int CW = $clog2(TIMEOUT);

    sched_state_e            state_q;
    logic [IW-1:0]           last_q;
    logic [IW-1:0]           id_q;
    logic [IW-1:0]           win_idx;
    logic [NUM_REQ-1:0]      win_gnt;
    logic [DATA_WIDTH-1:0]   win_data;
    logic [DATA_WIDTH-1:0]   opnd_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;
    logic [CW-1:0]           cnt_q;
    logic                    en_q;
    logic                    err_q;
    logic                    rsp_valid_q;
    logic                    can_grant;
    logic                    accept;

    custom_axi_ip_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req_i        (req_valid_i),
        .last_grant_i (last_q),
        .gnt_o        (win_gnt),
        .idx_o        (win_idx)
    );

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            win_data = (win_idx == IW'(k)) ? req_data_i[k*DATA_WIDTH +: DATA_WIDTH] : win_data;
        end
    end

    // The engine may still be finishing a timed-out job, so grants wait for IDLE.
    assign can_grant    = rst_ni && state_q == S_IDLE && eng_status_i == IDLE;
    assign req_ready_o  = can_grant ? win_gnt : '0;
    assign accept       = |(req_valid_i & req_ready_o);

    assign eng_data_o   = opnd_q;
    assign eng_enable_o = en_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = id_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = err_q;
    assign busy_o       = state_q != S_IDLE;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            last_q      <= IW'(NUM_REQ - 1);
            id_q        <= '0;
            opnd_q      <= '0;
            en_q        <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        opnd_q  <= win_data;
                        id_q    <= win_idx;
                        last_q  <= win_idx;
                        en_q    <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Engine status takes precedence over a coincident timeout.
                    if (eng_status_i == DONE) begin
                        state_q <= S_COLLECT;
                    end else if (eng_status_i == ERROR || cnt_q == CW'(TIMEOUT - 1)) begin
                        err_q       <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_COLLECT: begin
                    rsp_data_q  <= eng_result_i;
                    err_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_custom_axi_ip_sched.sv
// tb_custom_axi_ip_sched: randomized self-checking bench with an engine model and a round-robin/latency reference.
module tb_custom_axi_ip_sched;
    import custom_axi_ip_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data;
    logic            rsp_ready = 1'b1;
    logic [N-1:0]    req_ready;
    logic            rsp_valid, rsp_err, eng_enable, busy;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data, eng_data, eng_result;
    status_e         eng_status;
    logic [DW-1:0]   dat [N];
    int              total = 0;
    int              bad = 0;
    int              mode = 0;
    int              phase = 0;
    int              last = N - 1;
    logic [31:0]     eng_res = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_data[g*DW +: DW] = dat[g];
    end

    custom_axi_ip_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .rsp_ready_i  (rsp_ready),
        .eng_data_o   (eng_data),
        .eng_enable_o (eng_enable),
        .eng_status_i (eng_status),
        .eng_result_i (eng_result),
        .busy_o       (busy)
    );

    // Engine model: mode 0 = BUSY 1 then DONE, 1 = BUSY 1 then ERROR, 2 = BUSY 40 then DONE.
    function automatic int busy_len(int m);
        return m == 2 ? 40 : 1;
    endfunction

    always @(posedge clk) begin
        if (eng_enable) begin
            phase   <= 1;
            eng_res <= eng_data + 32'd1;
        end else if (phase != 0) begin
            phase <= (phase > busy_len(mode)) ? 0 : phase + 1;
        end
    end

    always_comb eng_status = phase == 0 ? IDLE : phase <= busy_len(mode) ? BUSY : mode == 1 ? ERROR : DONE;
    assign eng_result = eng_res;

    // Cycles from accept to first response cycle: engine reacts 2 cycles after accept,
    // DONE costs a collect cycle, ERROR goes straight to the response, timeout after TO wait cycles.
    function automatic int exp_lat(int m);
        int b;
        b = busy_len(m);
        if (b >= TO) return 2 + TO;
        return 2 + b + (m == 1 ? 1 : 2);
    endfunction

    function automatic logic [1:0] rr_pick(logic [N-1:0] v, int lst);
        logic [1:0] s;
        for (int off = 1; off <= N; off++) begin
            s = 2'((lst + off) % N);
            if (v[s]) return s;
        end
        return 2'(lst);
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        #1;
        while (req_ready == '0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        #1;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last = N - 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_data, eng_enable, busy} !== '0)
            begin bad++; $display("FAIL reset_outputs: got rdy=%b rv=%b id=%0d d=%h e=%b ed=%h en=%b busy=%b want all 0",
                req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_data, eng_enable, busy); end
        req_valid = '0;
        rst_n = 1'b1;
        last = N - 1;
        @(negedge clk); #1;
        total++;
        if ({busy, rsp_valid, req_ready} !== '0)
            begin bad++; $display("FAIL reset_idle: got busy=%b rv=%b rdy=%b want 0", busy, rsp_valid, req_ready); end
    endtask

    task automatic test_single();
        int n;
        mode = 0;
        rsp_ready = 1'b1;
        dat[2] = 32'hFF;
        req_valid = 4'b0100;
        wait_ready(n);
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        total++;
        if ({eng_enable, eng_data} !== {1'b1, 32'hFF})
            begin bad++; $display("FAIL single_issue: got en=%b data=%h want en=1 data=000000ff", eng_enable, eng_data); end
        @(negedge clk); #1;
        total++;
        if (eng_enable !== 1'b0) begin bad++; $display("FAIL single_pulse: got en=%b want 0", eng_enable); end
        wait_rsp(n);
        total++;
        if (n + 2 != exp_lat(0)) begin bad++; $display("FAIL single_latency: got %0d want %0d", n + 2, exp_lat(0)); end
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd2, 32'h100, 1'b0})
            begin bad++; $display("FAIL single_rsp: got v=%b id=%0d d=%h e=%b want v=1 id=2 d=00000100 e=0", rsp_valid, rsp_id, rsp_data, rsp_err); end
        last = 2;
        @(negedge clk); #1;
        total++;
        if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL single_done: got rv=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0] w;
        do_reset();
        mode = 0;
        for (int k = 0; k < N; k++) dat[2'(k)] = 32'(k);
        req_valid = '1;
        for (int t = 0; t < 5; t++) begin
            w = rr_pick(req_valid, last);
            wait_ready(n);
            total++;
            if (req_ready !== (4'b1 << w) || (t > 0 && n != 1))
                begin bad++; $display("FAIL rr_grant%0d: got %b after %0d cycles want %b after 1", t, req_ready, n, 4'b1 << w); end
            @(negedge clk);
            wait_rsp(n);
            total++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, w, dat[w] + 32'd1, 1'b0})
                begin bad++; $display("FAIL rr_rsp%0d: got v=%b id=%0d d=%h e=%b want id=%0d d=%h e=0", t, rsp_valid, rsp_id, rsp_data, rsp_err, w, dat[w] + 32'd1); end
            last = int'(w);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_error();
        int n;
        logic [1:0] w;
        mode = 1;
        dat[1] = $urandom;
        req_valid = 4'b0010;
        w = rr_pick(req_valid, last);
        wait_ready(n);
        total++;
        if (req_ready !== (4'b1 << w)) begin bad++; $display("FAIL err_grant: got %b want %b", req_ready, 4'b1 << w); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        total++;
        if (n + 1 != exp_lat(1)) begin bad++; $display("FAIL err_latency: got %0d want %0d", n + 1, exp_lat(1)); end
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, w, 32'h0, 1'b1})
            begin bad++; $display("FAIL err_rsp: got v=%b id=%0d d=%h e=%b want id=%0d d=0 e=1", rsp_valid, rsp_id, rsp_data, rsp_err, w); end
        last = int'(w);
        @(negedge clk);
        mode = 0;
    endtask

    task automatic test_timeout();
        int n;
        int seen;
        logic [1:0] w;
        mode = 2;
        dat[1] = $urandom;
        dat[3] = $urandom;
        req_valid = 4'b0010;
        w = rr_pick(req_valid, last);
        wait_ready(n);
        total++;
        if (req_ready !== (4'b1 << w)) begin bad++; $display("FAIL to_grant: got %b want %b", req_ready, 4'b1 << w); end
        @(negedge clk);
        req_valid = 4'b1000;
        wait_rsp(n);
        total++;
        if (n + 1 != exp_lat(2)) begin bad++; $display("FAIL to_latency: got %0d want %0d", n + 1, exp_lat(2)); end
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, w, 32'h0, 1'b1})
            begin bad++; $display("FAIL to_rsp: got v=%b id=%0d d=%h e=%b want id=%0d d=0 e=1", rsp_valid, rsp_id, rsp_data, rsp_err, w); end
        last = int'(w);
        n = 0;
        seen = 0;
        while (eng_status != IDLE && n < 100) begin
            if (req_ready !== '0) seen++;
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (seen != 0 || n >= 100) begin bad++; $display("FAIL to_gate: got %0d early grants in %0d busy cycles want 0", seen, n); end
        mode = 0;
        w = rr_pick(req_valid, last);
        total++;
        if (req_ready !== (4'b1 << w)) begin bad++; $display("FAIL to_regrant: got %b want %b", req_ready, 4'b1 << w); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, w, dat[w] + 32'd1, 1'b0})
            begin bad++; $display("FAIL to_next_rsp: got v=%b id=%0d d=%h e=%b want id=%0d d=%h", rsp_valid, rsp_id, rsp_data, rsp_err, w, dat[w] + 32'd1); end
        last = int'(w);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        int nbad;
        logic [1:0] w;
        logic [35:0] exp_rsp;
        mode = 0;
        rsp_ready = 1'b0;
        dat[0] = $urandom;
        dat[2] = $urandom;
        req_valid = 4'b0101;
        w = rr_pick(req_valid, last);
        wait_ready(n);
        total++;
        if (req_ready !== (4'b1 << w)) begin bad++; $display("FAIL bp_grant: got %b want %b", req_ready, 4'b1 << w); end
        @(negedge clk);
        req_valid[w] = 1'b0;
        wait_rsp(n);
        exp_rsp = {1'b1, w, dat[w] + 32'd1, 1'b0};
        nbad = 0;
        for (int c = 0; c < 10; c++) begin
            if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== exp_rsp || req_ready !== '0 || eng_enable !== 1'b0) nbad++;
            @(negedge clk); #1;
        end
        total++;
        if (nbad != 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles (last v=%b id=%0d d=%h) want 0", nbad, rsp_valid, rsp_id, rsp_data); end
        last = int'(w);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        w = rr_pick(req_valid, last);
        total++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b1 << w})
            begin bad++; $display("FAIL bp_release: got rv=%b rdy=%b want rv=0 rdy=%b", rsp_valid, req_ready, 4'b1 << w); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, w, dat[w] + 32'd1, 1'b0})
            begin bad++; $display("FAIL bp_next_rsp: got v=%b id=%0d d=%h e=%b want id=%0d d=%h", rsp_valid, rsp_id, rsp_data, rsp_err, w, dat[w] + 32'd1); end
        last = int'(w);
        @(negedge clk);
    endtask

    task automatic test_random();
        int n;
        int d;
        int nbad;
        logic [1:0] w;
        logic [N-1:0] pend;
        logic [N-1:0] add;
        logic [35:0] exp_rsp;
        pend = '0;
        for (int it = 0; it < 40; it++) begin
            add = 4'($urandom);
            if ((pend | add) == '0) add = 4'b1 << 2'($urandom_range(0, 3));
            for (int k = 0; k < N; k++) if (add[2'(k)] && !pend[2'(k)]) dat[2'(k)] = $urandom;
            pend |= add;
            mode = $urandom_range(0, 1);
            d = $urandom_range(0, 4);
            rsp_ready = (d == 0);
            req_valid = pend;
            w = rr_pick(pend, last);
            wait_ready(n);
            total++;
            if (req_ready !== (4'b1 << w)) begin bad++; $display("FAIL rnd_grant%0d: got %b want %b (pend %b)", it, req_ready, 4'b1 << w, pend); end
            @(negedge clk);
            pend[w] = 1'b0;
            req_valid = pend;
            #1;
            total++;
            if ({eng_enable, eng_data} !== {1'b1, dat[w]})
                begin bad++; $display("FAIL rnd_issue%0d: got en=%b d=%h want en=1 d=%h", it, eng_enable, eng_data, dat[w]); end
            wait_rsp(n);
            total++;
            if (n + 1 != exp_lat(mode)) begin bad++; $display("FAIL rnd_latency%0d: got %0d want %0d", it, n + 1, exp_lat(mode)); end
            exp_rsp = {1'b1, w, mode == 1 ? 32'h0 : dat[w] + 32'd1, mode == 1};
            total++;
            if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== exp_rsp)
                begin bad++; $display("FAIL rnd_rsp%0d: got %h want %h", it, {rsp_valid, rsp_id, rsp_data, rsp_err}, exp_rsp); end
            nbad = 0;
            for (int c = 0; c < d; c++) begin
                @(negedge clk); #1;
                if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== exp_rsp || req_ready !== '0 || eng_enable !== 1'b0) nbad++;
            end
            if (d > 0) begin
                total++;
                if (nbad != 0) begin bad++; $display("FAIL rnd_hold%0d: got %0d unstable cycles want 0", it, nbad); end
                rsp_ready = 1'b1;
            end
            last = int'(w);
            @(negedge clk);
        end
        req_valid = '0;
        mode = 0;
    endtask

    task automatic test_mid_reset();
        int n;
        int seen;
        do_reset();
        mode = 0;
        dat[2] = $urandom;
        req_valid = 4'b0100;
        wait_ready(n);
        total++;
        if (req_ready !== 4'b0100) begin bad++; $display("FAIL mr_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk); #1;
        total++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_data, eng_enable, busy} !== '0)
            begin bad++; $display("FAIL mr_outputs: got rdy=%b rv=%b id=%0d d=%h e=%b ed=%h en=%b busy=%b want all 0",
                req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_data, eng_enable, busy); end
        rst_n = 1'b1;
        last = N - 1;
        dat[0] = $urandom;
        dat[3] = $urandom;
        req_valid = 4'b1001;
        n = 0;
        seen = 0;
        #1;
        while (req_ready == '0 && n < 50) begin
            if (rsp_valid !== 1'b0) seen++;
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (req_ready !== 4'b0001 || seen != 0)
            begin bad++; $display("FAIL mr_priority: got rdy=%b stray rsp=%0d want rdy=0001 stray=0", req_ready, seen); end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n);
        total++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd0, dat[0] + 32'd1, 1'b0})
            begin bad++; $display("FAIL mr_rsp: got v=%b id=%0d d=%h e=%b want id=0 d=%h e=0", rsp_valid, rsp_id, rsp_data, rsp_err, dat[0] + 32'd1); end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < N; k++) dat[2'(k)] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_error();
        test_timeout();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000 want finish");
        $fatal(1);
    end

endmodule
